i2c_init_seq: RTL and testbench

//  Parametrised power-up register sequencer for I2C peripherals (OLED, camera, codec).

---
 rtl/i2c_init_seq.sv | 193 +++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_seq.sv
// i2c_init_seq: power-up register sequencer for I2C peripherals.
// Walks a synchronous ROM of CMD_NUM command words and hands each one to an
// I2C write master. A programmable idle gap follows every completed write, and
// NACKed writes are re-issued up to MAX_RETRY times before the sequence gives up.
//
// Handshakes: rom_en is a 1-cycle read strobe and rom_data is taken exactly one
// clock later; write_i2c_en is a 1-cycle request, after which the block waits
// in WAIT for a 1-cycle i2c_done pulse (i2c_ack_err is qualified by it).
// i2c_done outside WAIT is ignored. done is a 1-cycle pulse at the end of a
// sequence; error is sticky until the next accepted start.
module i2c_init_seq #(
    parameter int                CMD_NUM        = 28,
    parameter int                ADDR_W         = 5,
    parameter int                DATA_W         = 8,
    parameter int                REG_ADDR_EN    = 0,
    parameter logic [DATA_W-1:0] FIXED_REG_ADDR = '0,
    parameter int                SLEEP_CYCLES   = 50000,
    parameter int                MAX_RETRY      = 3,
    localparam int               ROM_W          = (REG_ADDR_EN + 1) * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic              write_i2c_en,
    output logic [DATA_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    input  logic              i2c_done,
    input  logic              i2c_ack_err,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] cmd_idx,
    output logic [2:0]        state_dbg
);

    // Counter widths never collapse to zero for the degenerate parameter values.
    localparam int SLEEP_W    = (SLEEP_CYCLES > 0) ? $clog2(SLEEP_CYCLES + 1) : 1;
    localparam int SLEEP_LAST = (SLEEP_CYCLES > 1) ? (SLEEP_CYCLES - 1) : 0;
    localparam int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SLEEP_W-1:0] SLEEP_LAST_C = SLEEP_W'(SLEEP_LAST);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C  = RETRY_W'(MAX_RETRY);
    // One extra bit so CMD_NUM == 2**ADDR_W terminates instead of wrapping.
    localparam logic [ADDR_W:0]    CMD_END      = (ADDR_W + 1)'(CMD_NUM);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT     = 3'd4,
        S_SLEEP    = 3'd5,
        S_COMPLETE = 3'd6,
        S_FAIL     = 3'd7
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     cmd_cnt_q;
    logic [RETRY_W-1:0]  retry_cnt_q;
    logic [SLEEP_W-1:0]  sleep_cnt_q;
    logic                retry_pend_q;
    logic [DATA_W-1:0]   rom_reg_addr;
    logic                sleep_exp;
    logic                wr_ok;
    logic                wr_retry;
    logic                wr_fail;

    // Register-address field of the ROM word, or the fixed control byte.
    generate
        if (REG_ADDR_EN != 0) begin : g_rom_addr
            assign rom_reg_addr = rom_data[ROM_W-1:DATA_W];
        end else begin : g_fixed_addr
            assign rom_reg_addr = FIXED_REG_ADDR;
        end
    endgenerate

    assign sleep_exp = (sleep_cnt_q == SLEEP_LAST_C);
    assign wr_ok     = i2c_done && !i2c_ack_err;
    assign wr_retry  = i2c_done && i2c_ack_err && (retry_cnt_q < MAX_RETRY_C);
    assign wr_fail   = i2c_done && i2c_ack_err && !(retry_cnt_q < MAX_RETRY_C);

    assign cmd_idx   = cmd_cnt_q[ADDR_W-1:0];
    assign rom_addr  = cmd_cnt_q[ADDR_W-1:0];
    assign state_dbg = state_q;

    // Next-state decode and the state-decoded strobes.
    always_comb begin
        state_d      = state_q;
        rom_en       = 1'b0;
        write_i2c_en = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_en  = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                write_i2c_en = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (wr_ok || wr_retry) state_d = S_SLEEP;
                else if (wr_fail)      state_d = S_FAIL;
            end
            S_SLEEP: begin
                if (sleep_exp) begin
                    if (retry_pend_q)                  state_d = S_ISSUE;
                    else if (cmd_cnt_q == CMD_END)     state_d = S_COMPLETE;
                    else                               state_d = S_FETCH;
                end
            end
            S_COMPLETE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset and abort win over every other event.
    always_ff @(posedge clk) begin
        if (reset || abort) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Command index, retry/sleep counters, latched write and sticky error.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            cmd_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            sleep_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            reg_addr     <= '0;
            reg_data     <= '0;
            if (reset) error <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error        <= 1'b0;
                        cmd_cnt_q    <= '0;
                        retry_cnt_q  <= '0;
                        retry_pend_q <= 1'b0;
                    end
                end
                S_LATCH: begin
                    reg_data <= rom_data[DATA_W-1:0];
                    reg_addr <= rom_reg_addr;
                end
                S_WAIT: begin
                    sleep_cnt_q <= '0;
                    if (wr_ok) begin
                        cmd_cnt_q    <= cmd_cnt_q + 1'b1;
                        retry_cnt_q  <= '0;
                        retry_pend_q <= 1'b0;
                    end else if (wr_retry) begin
                        retry_cnt_q  <= retry_cnt_q + 1'b1;
                        retry_pend_q <= 1'b1;
                    end
                end
                S_SLEEP: begin
                    if (sleep_exp) begin
                        sleep_cnt_q  <= '0;
                        retry_pend_q <= 1'b0;
                    end else begin
                        sleep_cnt_q <= sleep_cnt_q + 1'b1;
                    end
                end
                S_FAIL: begin
                    error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Testbench for i2c_init_seq: a 4-command DUT with 16-bit ROM words and a
// 10-cycle gap, plus a 32-command DUT with 8-bit words and no gap.
// Each expected write is queued as {gap, reg_addr, reg_data}; gap is the exact
// number of clocks since the previous write_i2c_en (0 = first write, no check).
module tb_i2c_init_seq;

    localparam int D_LAT = 3;   // I2C model: clocks from request to i2c_done

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    initial forever #5 clk = ~clk;

    // ---------------- DUT A signals ----------------
    logic        start_a = 1'b0, abort_a = 1'b0;
    logic        rom_en_a, wr_a, busy_a, done_a, error_a;
    logic [1:0]  rom_addr_a, cmd_idx_a;
    logic [15:0] rom_data_a = '0;
    logic [7:0]  reg_addr_a, reg_data_a;
    logic        i2c_done_a = 1'b0, ack_err_a = 1'b0;
    logic [2:0]  state_a;

    // ---------------- DUT B signals ----------------
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic        rom_en_b, wr_b, busy_b, done_b, error_b;
    logic [4:0]  rom_addr_b, cmd_idx_b;
    logic [7:0]  rom_data_b = '0;
    logic [7:0]  reg_addr_b, reg_data_b;
    logic        i2c_done_b = 1'b0, ack_err_b = 1'b0;
    logic [2:0]  state_b;

    i2c_init_seq #(
        .CMD_NUM(4), .ADDR_W(2), .DATA_W(8), .REG_ADDR_EN(1),
        .FIXED_REG_ADDR(8'h00), .SLEEP_CYCLES(10), .MAX_RETRY(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .write_i2c_en(wr_a), .reg_addr(reg_addr_a), .reg_data(reg_data_a),
        .i2c_done(i2c_done_a), .i2c_ack_err(ack_err_a),
        .busy(busy_a), .done(done_a), .error(error_a), .cmd_idx(cmd_idx_a),
        .state_dbg(state_a)
    );

    i2c_init_seq #(
        .CMD_NUM(32), .ADDR_W(5), .DATA_W(8), .REG_ADDR_EN(0),
        .FIXED_REG_ADDR(8'h00), .SLEEP_CYCLES(0), .MAX_RETRY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .write_i2c_en(wr_b), .reg_addr(reg_addr_b), .reg_data(reg_data_b),
        .i2c_done(i2c_done_b), .i2c_ack_err(ack_err_b),
        .busy(busy_b), .done(done_b), .error(error_b), .cmd_idx(cmd_idx_b),
        .state_dbg(state_b)
    );

    // ---------------- sync ROM models ----------------
    logic [15:0] rom_a [4];
    logic [7:0]  rom_b [32];
    initial begin
        rom_a[0] = 16'hA001; rom_a[1] = 16'hA102;
        rom_a[2] = 16'hA203; rom_a[3] = 16'hA304;
        for (int i = 0; i < 32; i++) rom_b[i] = 8'(8'h40 + i);
    end
    always @(posedge clk) if (rom_en_a) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) if (rom_en_b) rom_data_b <= rom_b[rom_addr_b];

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_a_q[$];
    logic [23:0] exp_b_q[$];
    int errors = 0;
    int checks = 0;
    int cyc_a = 0, last_wr_a = 0, wr_cnt_a = 0, rom_cnt_a = 0, done_cnt_a = 0;
    int cyc_b = 0, last_wr_b = 0, wr_cnt_b = 0, rom_cnt_b = 0, done_cnt_b = 0;
    int wr_at_done_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- I2C slave models ----------------
    logic [7:0] nack_data_a = 8'h00;
    int         nack_left_a = 0;
    logic       stray_a = 1'b0;
    logic       nack_now_a;

    // DUT A slave: NACKs the chosen data byte nack_left_a times; optional stray done in SLEEP.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_a) begin
                nack_now_a = (reg_data_a == nack_data_a) && (nack_left_a > 0);
                if (nack_now_a) nack_left_a--;
                repeat (D_LAT) @(negedge clk);
                i2c_done_a = 1'b1;
                ack_err_a  = nack_now_a;
                @(negedge clk);
                i2c_done_a = 1'b0;
                ack_err_a  = 1'b0;
                if (stray_a && !nack_now_a) begin
                    repeat (3) @(negedge clk);
                    i2c_done_a = 1'b1;
                    @(negedge clk);
                    i2c_done_a = 1'b0;
                end
            end
        end
    end

    // DUT B slave: acks everything.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_b) begin
                repeat (D_LAT) @(negedge clk);
                i2c_done_b = 1'b1;
                @(negedge clk);
                i2c_done_b = 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    // DUT A: pop and compare each write request, count strobes.
    always @(negedge clk) begin
        logic [23:0] e;
        cyc_a++;
        if (rom_en_a) rom_cnt_a++;
        if (done_a) done_cnt_a++;
        if (wr_a) begin
            wr_cnt_a++;
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_a_unexpected: got %h_%h expected none", reg_addr_a, reg_data_a);
            end else begin
                e = exp_a_q.pop_front();
                chk("wr_a_addr", 32'(reg_addr_a), 32'(e[15:8]));
                chk("wr_a_data", 32'(reg_data_a), 32'(e[7:0]));
                if (e[23:16] != 8'd0) chk("wr_a_gap", cyc_a - last_wr_a, 32'(e[23:16]));
            end
            last_wr_a = cyc_a;
        end
    end

    // DUT B: same, and record how many writes had happened when done fired.
    always @(negedge clk) begin
        logic [23:0] e;
        cyc_b++;
        if (rom_en_b) rom_cnt_b++;
        if (done_b) begin
            done_cnt_b++;
            wr_at_done_b = wr_cnt_b;
        end
        if (wr_b) begin
            wr_cnt_b++;
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_b_unexpected: got %h_%h expected none", reg_addr_b, reg_data_b);
            end else begin
                e = exp_b_q.pop_front();
                chk("wr_b_addr", 32'(reg_addr_b), 32'(e[15:8]));
                chk("wr_b_data", 32'(reg_data_b), 32'(e[7:0]));
                if (e[23:16] != 8'd0) chk("wr_b_gap", cyc_b - last_wr_b, 32'(e[23:16]));
            end
            last_wr_b = cyc_b;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_abort_a();
        @(posedge clk); #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
    endtask

    // which: 0 = done_cnt_a, 1 = wr_cnt_a, 2 = done_cnt_b
    task automatic wait_cnt(input string name, input int which, input int target, input int budget);
        int cur;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            cur = (which == 0) ? done_cnt_a : (which == 1) ? wr_cnt_a : done_cnt_b;
            if (cur >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: count %0d expected %0d within %0d clks", name, cur, target, budget);
    endtask

    task automatic push_a(input logic [7:0] gap, input logic [15:0] w);
        exp_a_q.push_back({gap, w});
    endtask

    task automatic push_clean_a();
        logic [15:0] vec [4];
        vec[0] = 16'hA001; vec[1] = 16'hA102; vec[2] = 16'hA203; vec[3] = 16'hA304;
        push_a(8'd0, vec[0]);
        for (int i = 1; i < 4; i++) push_a(8'd16, vec[i]);
    endtask

    // Run a clean 4-command sequence on DUT A and check the totals.
    task automatic run_clean_a(input string tag);
        int b_rom, b_wr, b_done;
        b_rom = rom_cnt_a; b_wr = wr_cnt_a; b_done = done_cnt_a;
        push_clean_a();
        pulse_start_a();
        wait_cnt({tag, "_done"}, 0, b_done + 1, 400);
        repeat (2) @(negedge clk);
        chk({tag, "_rom_cnt"}, rom_cnt_a - b_rom, 4);
        chk({tag, "_wr_cnt"}, wr_cnt_a - b_wr, 4);
        chk({tag, "_done_cnt"}, done_cnt_a - b_done, 1);
        chk({tag, "_error"}, 32'(error_a), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_q_empty"}, exp_a_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int b_rom, b_wr, b_done;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_error", 32'(error_a), 0);
        chk("rst_cmd_idx", 32'(cmd_idx_a), 0);
        chk("rst_rom_en", 32'(rom_en_a), 0);
        chk("rst_wr", 32'(wr_a), 0);
        chk("rst_state", 32'(state_a), 0);
        chk("rst_reg", 32'({reg_addr_a, reg_data_a}), 0);

        // 1: all acked
        run_clean_a("t1");

        // 2: command 1 NACKed once, retried without a ROM re-read
        nack_data_a = 8'h02; nack_left_a = 1;
        b_rom = rom_cnt_a; b_wr = wr_cnt_a; b_done = done_cnt_a;
        push_a(8'd0, 16'hA001); push_a(8'd16, 16'hA102); push_a(8'd14, 16'hA102);
        push_a(8'd16, 16'hA203); push_a(8'd16, 16'hA304);
        pulse_start_a();
        wait_cnt("t2_done", 0, b_done + 1, 400);
        repeat (2) @(negedge clk);
        chk("t2_rom_cnt", rom_cnt_a - b_rom, 4);
        chk("t2_wr_cnt", wr_cnt_a - b_wr, 5);
        chk("t2_done_cnt", done_cnt_a - b_done, 1);
        chk("t2_error", 32'(error_a), 0);
        chk("t2_q_empty", exp_a_q.size(), 0);

        // 3: command 2 NACKed every time -> three issues, then fail
        nack_data_a = 8'h03; nack_left_a = 99;
        b_rom = rom_cnt_a; b_wr = wr_cnt_a; b_done = done_cnt_a;
        push_a(8'd0, 16'hA001); push_a(8'd16, 16'hA102); push_a(8'd16, 16'hA203);
        push_a(8'd14, 16'hA203); push_a(8'd14, 16'hA203);
        pulse_start_a();
        wait_cnt("t3_done", 0, b_done + 1, 400);
        repeat (2) @(negedge clk);
        nack_left_a = 0;
        chk("t3_rom_cnt", rom_cnt_a - b_rom, 3);
        chk("t3_wr_cnt", wr_cnt_a - b_wr, 5);
        chk("t3_done_cnt", done_cnt_a - b_done, 1);
        chk("t3_error", 32'(error_a), 1);
        chk("t3_cmd_idx", 32'(cmd_idx_a), 2);
        chk("t3_busy", 32'(busy_a), 0);
        chk("t3_q_empty", exp_a_q.size(), 0);

        // abort holds the sticky error
        pulse_abort_a();
        @(negedge clk);
        chk("abort_err_held", 32'(error_a), 1);

        // 4: reset during WAIT of command 2
        b_done = done_cnt_a; b_wr = wr_cnt_a;
        push_a(8'd0, 16'hA001); push_a(8'd16, 16'hA102); push_a(8'd16, 16'hA203);
        pulse_start_a();
        @(negedge clk);
        chk("t4_err_cleared", 32'(error_a), 0);
        wait_cnt("t4_wr3", 1, b_wr + 3, 200);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t4_state", 32'(state_a), 0);
        chk("t4_busy", 32'(busy_a), 0);
        chk("t4_outs", 32'({rom_en_a, wr_a, done_a, error_a, cmd_idx_a}), 0);
        chk("t4_reg", 32'({reg_addr_a, reg_data_a}), 0);
        repeat (10) @(negedge clk);
        chk("t4_no_done", done_cnt_a - b_done, 0);
        chk("t4_q_empty", exp_a_q.size(), 0);
        run_clean_a("t4_rerun");

        // 5: start while busy and a stray i2c_done in SLEEP
        stray_a = 1'b1;
        b_rom = rom_cnt_a; b_wr = wr_cnt_a; b_done = done_cnt_a;
        push_clean_a();
        pulse_start_a();
        wait_cnt("t5_wr1", 1, b_wr + 1, 100);
        pulse_start_a();
        chk("t5_busy_mid", 32'(busy_a), 1);
        wait_cnt("t5_done", 0, b_done + 1, 400);
        repeat (2) @(negedge clk);
        stray_a = 1'b0;
        chk("t5_rom_cnt", rom_cnt_a - b_rom, 4);
        chk("t5_wr_cnt", wr_cnt_a - b_wr, 4);
        chk("t5_done_cnt", done_cnt_a - b_done, 1);
        chk("t5_q_empty", exp_a_q.size(), 0);
        repeat (10) @(negedge clk);

        // abort mid-sequence: back to IDLE, no done
        b_done = done_cnt_a; b_wr = wr_cnt_a;
        push_a(8'd0, 16'hA001);
        pulse_start_a();
        wait_cnt("ab_wr1", 1, b_wr + 1, 100);
        pulse_abort_a();
        @(negedge clk);
        chk("ab_busy", 32'(busy_a), 0);
        chk("ab_cmd_idx", 32'(cmd_idx_a), 0);
        repeat (10) @(negedge clk);
        chk("ab_no_done", done_cnt_a - b_done, 0);
        chk("ab_q_empty", exp_a_q.size(), 0);

        // 6: 32 commands, fixed reg_addr, no gap, full-range index
        b_rom = rom_cnt_b; b_wr = wr_cnt_b; b_done = done_cnt_b;
        for (int i = 0; i < 32; i++)
            exp_b_q.push_back({(i == 0) ? 8'd0 : 8'd7, 8'h00, 8'(8'h40 + i)});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_cnt("t6_done", 2, b_done + 1, 800);
        repeat (2) @(negedge clk);
        chk("t6_rom_cnt", rom_cnt_b - b_rom, 32);
        chk("t6_wr_cnt", wr_cnt_b - b_wr, 32);
        chk("t6_done_cnt", done_cnt_b - b_done, 1);
        chk("t6_wr_at_done", wr_at_done_b - b_wr, 32);
        chk("t6_error", 32'(error_b), 0);
        chk("t6_busy", 32'(busy_b), 0);
        chk("t6_q_empty", exp_b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
